// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU request scheduler: op codes, FSM states and a
// small modular-increment helper used by the round-robin search.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  // (base + off) mod n, valid for base < n and off <= n
  function automatic int unsigned rr_wrap(int unsigned base, int unsigned off,
                                          int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from LAST+1 with wrap-around.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         REQ,
  input  logic [$clog2(N)-1:0] LAST,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] GNT_IDX
);

  localparam int IDW = $clog2(N);

  // cand[k] is the index examined at search step k+1 after LAST
  logic [N-1:0][IDW-1:0] cand;
  logic [N-1:0]          hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = IDW'(rr_wrap(int'(LAST), gi + 1, N));
    assign hit[gi]  = REQ[cand[gi]];
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    GNT     = '0;
    GNT_IDX = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && hit[k]) begin
        found          = 1'b1;
        GNT_IDX        = cand[k];
        GNT[cand[k]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one four-function ALU between N_REQ requesters: round-robin grant,
// single operation in flight, fixed-latency capture, tagged response channel.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              REQ_VALID,
  output logic [N_REQ-1:0]              REQ_READY,
  input  logic [N_REQ-1:0][1:0]         REQ_OP,
  input  logic [N_REQ-1:0][WIDTH-1:0]   REQ_A,
  input  logic [N_REQ-1:0][WIDTH-1:0]   REQ_B,
  output logic                          EN,
  output logic [1:0]                    SEL,
  output logic [WIDTH-1:0]              ALU_A,
  output logic [WIDTH-1:0]              ALU_B,
  input  logic [WIDTH-1:0]              ALU_RESULT,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [WIDTH-1:0]              RSP_DATA,
  output logic [$clog2(N_REQ)-1:0]      RSP_ID,
  output logic                          BUSY
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ALU_LAT - 1);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(N_REQ - 1);

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             en_q, en_d;
  alu_op_t          sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_req;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .REQ    (REQ_VALID),
    .LAST   (last_q),
    .GNT    (gnt),
    .GNT_IDX(gnt_idx)
  );

  assign any_req = |REQ_VALID;

  // Accept is only offered while idle and never while reset is applied
  assign REQ_READY = (state_q == IDLE && !RST) ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    en_d        = 1'b0;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          last_d  = gnt_idx;
          sel_d   = alu_op_t'(REQ_OP[gnt_idx]);
          a_d     = REQ_A[gnt_idx];
          b_d     = REQ_B[gnt_idx];
          en_d    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = ALU_RESULT;
          rsp_id_d    = last_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      sel_q       <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
    end
  end

  assign EN        = en_q;
  assign SEL       = sel_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ID    = rsp_id_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: vector table plus scoreboard on a latency-1
// instance, and a latency-3 instance for the reset-during-WAIT sequence.
module tb_alu_req_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic             rst0, en0, rsp_valid0, rsp_ready0, busy0;
  logic [N-1:0]     valid0, ready0;
  logic [N-1:0][1:0]   op0;
  logic [N-1:0][W-1:0] a0, b0;
  logic [1:0]       sel0;
  logic [W-1:0]     alu_a0, alu_b0, res0, rsp_data0;
  logic [1:0]       rsp_id0;

  // Latency-3 instance
  logic             rst1, en1, rsp_valid1, rsp_ready1, busy1;
  logic [N-1:0]     valid1, ready1;
  logic [N-1:0][1:0]   op1;
  logic [N-1:0][W-1:0] a1, b1;
  logic [1:0]       sel1;
  logic [W-1:0]     alu_a1, alu_b1, res1, rsp_data1;
  logic [1:0]       rsp_id1;
  logic [W-1:0]     p0, p1;

  alu_req_scheduler #(.N_REQ(N), .WIDTH(W), .ALU_LAT(1)) dut0 (
    .CLK(clk), .RST(rst0), .REQ_VALID(valid0), .REQ_READY(ready0),
    .REQ_OP(op0), .REQ_A(a0), .REQ_B(b0), .EN(en0), .SEL(sel0),
    .ALU_A(alu_a0), .ALU_B(alu_b0), .ALU_RESULT(res0),
    .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready0), .RSP_DATA(rsp_data0),
    .RSP_ID(rsp_id0), .BUSY(busy0)
  );

  alu_req_scheduler #(.N_REQ(N), .WIDTH(W), .ALU_LAT(3)) dut1 (
    .CLK(clk), .RST(rst1), .REQ_VALID(valid1), .REQ_READY(ready1),
    .REQ_OP(op1), .REQ_A(a1), .REQ_B(b1), .EN(en1), .SEL(sel1),
    .ALU_A(alu_a1), .ALU_B(alu_b1), .ALU_RESULT(res1),
    .RSP_VALID(rsp_valid1), .RSP_READY(rsp_ready1), .RSP_DATA(rsp_data1),
    .RSP_ID(rsp_id1), .BUSY(busy1)
  );

  function automatic logic [W-1:0] alu_ref(logic [1:0] op, logic [W-1:0] a,
                                           logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Behavioural ALUs: result valid exactly ALU_LAT cycles after EN, junk otherwise
  always_ff @(posedge clk) res0 <= en0 ? alu_ref(sel0, alu_a0, alu_b0) : 8'h5A;
  always_ff @(posedge clk) begin
    p0   <= en1 ? alu_ref(sel1, alu_a1, alu_b1) : 8'h5A;
    p1   <= p0;
    res1 <= p1;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   grant_cnt = 0;
  int   en_cnt    = 0;

  // Scoreboard on the latency-1 instance: push at accept, pop at response
  always @(negedge clk) begin
    exp_t e;
    if (!rst0) begin
      for (int i = 0; i < N; i++) begin
        if (ready0[i] && valid0[i]) begin
          sb_q.push_back('{2'(i), alu_ref(op0[i], a0[i], b0[i])});
          grant_log.push_back(i);
          grant_cnt++;
        end
      end
      if (en0) en_cnt++;
      if (rsp_valid0 && rsp_ready0) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("rsp id=%0d data=%02h (expected id=%0d data=%02h)",
                   rsp_id0, rsp_data0, e.id, e.data);
          check("sb_id", 32'(rsp_id0), 32'(e.id));
          check("sb_data", 32'(rsp_data0), 32'(e.data));
        end
      end
    end
  end

  typedef struct {
    int           id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  vec_t vecs[6];

  // One request through dut0 with cycle-exact checks; starts and ends at posedge+1
  task automatic run_vec(input vec_t v);
    int  k;
    valid0[v.id] = 1'b1;
    op0[v.id]    = v.op;
    a0[v.id]     = v.a;
    b0[v.id]     = v.b;
    @(negedge clk);
    for (k = 0; k < 20 && ready0 == '0; k++) @(negedge clk);
    check("accept_ready", 32'(ready0), 32'(1) << v.id);
    @(posedge clk) #1 valid0[v.id] = 1'b0;
    @(negedge clk);
    check("en_pulse", 32'(en0), 32'd1);
    check("sel_in_en", 32'(sel0), 32'(v.op));
    check("alu_a", 32'(alu_a0), 32'(v.a));
    check("alu_b", 32'(alu_b0), 32'(v.b));
    @(negedge clk);
    check("en_single", 32'(en0), 32'd0);
    k = 2;
    while (!rsp_valid0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 32'(k), 32'd3);
    check("rsp_data", 32'(rsp_data0), 32'(v.res));
    check("rsp_id", 32'(rsp_id0), 32'(v.id));
    @(posedge clk) #1;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int g_base, e_base;
  int first_id, first_k, stale;
  logic [W-1:0] first_data;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = '1; valid1 = '1;
    op0 = '0; a0 = '0; b0 = '0;
    op1 = '0; a1 = '0; b1 = '0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    vecs[0] = '{2, 2'b00, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{0, 2'b01, 8'h02, 8'h05, 8'hFD};
    vecs[2] = '{1, 2'b11, 8'hF0, 8'h0F, 8'hFF};
    vecs[3] = '{3, 2'b10, 8'hCC, 8'hAA, 8'h88};
    vecs[4] = '{1, 2'b00, 8'hFF, 8'h01, 8'h00};
    vecs[5] = '{3, 2'b01, 8'h00, 8'h01, 8'hFF};

    // Reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(ready0), 32'd0);
      check("rst_en", 32'(en0), 32'd0);
      check("rst_sel", 32'(sel0), 32'd0);
      check("rst_alu_a", 32'(alu_a0), 32'd0);
      check("rst_alu_b", 32'(alu_b0), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
      check("rst_rsp_data", 32'(rsp_data0), 32'd0);
      check("rst_rsp_id", 32'(rsp_id0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
    end
    @(posedge clk) #1;
    rst0 = 1'b0; rst1 = 1'b0;
    valid0 = '0; valid1 = '0;

    for (int i = 0; i < 6; i++) begin
      $display("vec %0d: id=%0d op=%0d a=%02h b=%02h", i, vecs[i].id,
               vecs[i].op, vecs[i].a, vecs[i].b);
      run_vec(vecs[i]);
    end

    // Round-robin with all four requesters valid (LAST is 3 here)
    for (int i = 0; i < N; i++) begin
      op0[i] = 2'(i);
      a0[i]  = W'(16 + i);
      b0[i]  = 8'h03;
    end
    grant_log.delete();
    g_base = grant_cnt;
    e_base = en_cnt;
    valid0 = '1;
    for (int k = 0; k < 200 && (grant_cnt - g_base) < 6; k++) @(negedge clk);
    @(posedge clk) #1 valid0 = '0;
    for (int k = 0; k < 200 && (sb_q.size() != 0 || busy0); k++) @(negedge clk);
    check("rr_grant_count", 32'(grant_cnt - g_base), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));
    check("rr_en_count", 32'(en_cnt - e_base), 32'd6);
    check("rr_drained", 32'(sb_q.size()), 32'd0);

    // Response back-pressure with another requester waiting
    @(posedge clk) #1;
    rsp_ready0 = 1'b0;
    op0[1] = 2'b01; a0[1] = 8'h40; b0[1] = 8'h01;
    valid0[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20 && !ready0[1]; k++) @(negedge clk);
    check("bp_accept", 32'(ready0), 32'h2);
    @(posedge clk) #1;
    valid0[1] = 1'b0;
    op0[2] = 2'b11; a0[2] = 8'h30; b0[2] = 8'h03;
    valid0[2] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20 && !rsp_valid0; k++) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      check("bp_rsp_valid", 32'(rsp_valid0), 32'd1);
      check("bp_rsp_data", 32'(rsp_data0), 32'h3F);
      check("bp_rsp_id", 32'(rsp_id0), 32'd1);
      check("bp_req_ready", 32'(ready0), 32'd0);
      check("bp_en", 32'(en0), 32'd0);
      @(negedge clk);
    end
    @(posedge clk) #1 rsp_ready0 = 1'b1;
    @(negedge clk);
    check("bp_handshake_no_grant", 32'(ready0), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(ready0), 32'h4);
    @(posedge clk) #1 valid0[2] = 1'b0;
    for (int k = 0; k < 50 && (sb_q.size() != 0 || busy0); k++) @(negedge clk);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Reset during WAIT on the latency-3 instance
    @(posedge clk) #1;
    op1[1] = 2'b00; a1[1] = 8'h01; b1[1] = 8'h01;
    valid1[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20 && !ready1[1]; k++) @(negedge clk);
    check("rw_accept", 32'(ready1), 32'h2);
    @(posedge clk) #1 valid1[1] = 1'b0;
    @(negedge clk);
    check("rw_en", 32'(en1), 32'd1);
    @(posedge clk) #1 rst1 = 1'b1;
    @(negedge clk);
    check("rw_busy_in_wait", 32'(busy1), 32'd1);
    @(posedge clk) #1 rst1 = 1'b0;
    @(negedge clk);
    check("rw_en_after", 32'(en1), 32'd0);
    check("rw_busy_after", 32'(busy1), 32'd0);
    check("rw_rsp_valid_after", 32'(rsp_valid1), 32'd0);
    check("rw_alu_a_after", 32'(alu_a1), 32'd0);
    @(posedge clk) #1;
    op1[0] = 2'b11; a1[0] = 8'h21; b1[0] = 8'h42;
    op1[3] = 2'b00; a1[3] = 8'h01; b1[3] = 8'h01;
    valid1 = 4'b1001;
    @(negedge clk);
    check("rw_first_grant", 32'(ready1), 32'h1);
    @(posedge clk) #1 valid1[0] = 1'b0;
    first_id = -1; first_k = -1; stale = 0; first_data = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid1) begin
        if (rsp_id1 == 2'd1) stale++;
        if (first_id < 0) begin
          first_id   = int'(rsp_id1);
          first_data = rsp_data1;
          first_k    = k;
        end
      end
    end
    valid1 = '0;
    check("rw_first_rsp_id", 32'(first_id), 32'd0);
    check("rw_first_rsp_data", 32'(first_data), 32'h63);
    check("rw_first_rsp_latency", 32'(first_k), 32'd5);
    check("rw_no_stale_rsp", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Sequencing controller that shares the four-function ALU (ADD/SUB/AND/OR, selected through the 1-to-4 enable demux) between `N_REQ` requesters. It round-robin arbitrates operation requests and drives the demux `EN`/`SEL` and the ALU operands. It waits a fixed ALU latency, captures the result, and returns it on a single response channel tagged with the requester ID. It sits between the requester front-ends and the ALU/demux datapath, and only one operation is in flight at a time.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand and result width.
- `ALU_LAT`, default 1: cycles from the `EN` cycle to a valid `ALU_RESULT`, ≥1.
- `CLK`, input, 1: the single clock.
- `RST`, input, 1: synchronous, active-high reset.
- `REQ_VALID`, input, `N_REQ`: per-requester request valid.
- `REQ_READY`, output, `N_REQ`: per-requester accept, one-hot or zero.
- `REQ_OP`, input, `N_REQ`×2: op code, 00 ADD, 01 SUB, 10 AND, 11 OR.
- `REQ_A` / `REQ_B`, input, `N_REQ`×`WIDTH`: operands.
- `EN`, output, 1: demux enable.
- `SEL`, output, 2: demux select, equal to the op code.
- `ALU_A` / `ALU_B`, output, `WIDTH`: operands to the ALU.
- `ALU_RESULT`, input, `WIDTH`: ALU output.
- `RSP_VALID`, output, 1: response valid.
- `RSP_READY`, input, 1: response accept.
- `RSP_DATA`, output, `WIDTH`: captured result.
- `RSP_ID`, output, clog2(`N_REQ`): index of the served requester.
- `BUSY`, output, 1: high whenever state ≠ IDLE.

## Operation
- FSM has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `REQ_VALID` is high, grant the first valid index searching from `LAST+1` mod `N_REQ` upward, with wrap.
  - `REQ_READY[g]` is high in this cycle. It is combinational and asserted only in IDLE.
  - Latch `op`, `A`, `B` and `g`; set `LAST` = `g`; go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - `EN` = 1 for exactly one cycle, with `SEL` = latched op.
  - `ALU_A` and `ALU_B` carry the latched operands. They stay driven through WAIT and are held afterwards.
  - Go to WAIT with counter = `ALU_LAT`-1.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0: register `ALU_RESULT` into `RSP_DATA`, set `RSP_ID` = `g`, and go to RESP.
- **RESP**
  - `RSP_VALID` = 1 with `RSP_DATA` and `RSP_ID` held stable.
  - On `RSP_VALID && RSP_READY`, return to IDLE. No new grant is made in that same cycle.
- **Requester rules**
  - A requester holds `REQ_VALID` and its payload stable until it sees `REQ_READY`.
  - Dropping `REQ_VALID` before `REQ_READY` is legal; arbitration is re-evaluated every IDLE cycle.
- **Arithmetic:** the scheduler never alters data. Results are passed through at `WIDTH` bits, and SUB wrap-around is the ALU's concern.
- **Reset**
  - Reset applies in any state, mid-operation included. The in-flight op is dropped and no response is produced.
  - After reset: state = IDLE, `LAST` = `N_REQ`-1 (so requester 0 has first priority), counter = 0.
  - Output values: `EN`, `SEL`, `ALU_A`, `ALU_B`, `RSP_VALID`, `RSP_DATA`, `RSP_ID`, `REQ_READY` and `BUSY` are all 0.
- **Back-pressure:** while `RSP_READY` is low, the block stays in RESP indefinitely. No `REQ_READY` or `EN` is issued during that time.

## Timing
- Request accepted in cycle t, meaning `REQ_READY` is high in cycle t.
- `EN` is high in cycle t+1.
- `ALU_RESULT` is sampled at the end of cycle t+1+`ALU_LAT`.
- `RSP_VALID` is first high in cycle t+2+`ALU_LAT`.
- Minimum spacing between accepts is 3+`ALU_LAT` cycles, with `RSP_READY` held high.
- All outputs are registered except `REQ_READY`, which is combinational from `REQ_VALID`, state and `LAST`.
- `EN` is never high outside ISSUE. `SEL` holds its last value when `EN` = 0.

## Structure
- Shared package `alu_sched_pkg` contains:
  - `alu_op_t` enum: `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_AND`=2'b10, `OP_OR`=2'b11.
  - `sched_state_t` enum: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- Sub-module `rr_arbiter` (parameter `N`) is the natural split:
  - Inputs: `REQ` vector, `LAST` pointer.
  - Outputs: one-hot `GNT` and encoded `GNT_IDX`, purely combinational.
  - The FSM, operand latches, latency counter and response registers live in the top level.

## Test plan
- **Reset:** hold `RST` for 2 cycles with all requesters valid → every output is 0, and `REQ_READY` is 0 during reset.
- **Single ADD:** requester 2 sends ADD, A=5, B=3, with `ALU_LAT`=1 and a behavioural ALU model →
  - `REQ_READY` = 4'b0100 in cycle 0.
  - `EN` = 1 and `SEL` = 00 in cycle 1.
  - `RSP_VALID` = 1 in cycle 3 with `RSP_DATA` = 8 and `RSP_ID` = 2.
- **Round-robin fairness:** all four requesters valid continuously → grant order 0,1,2,3,0,1, with exactly one `EN` pulse per grant.
- **Response back-pressure:** hold `RSP_READY` low for 5 cycles during RESP → `RSP_VALID`, `RSP_DATA` and `RSP_ID` stay stable, and `REQ_READY` and `EN` stay 0. The next grant follows one cycle after the handshake.
- **Reset mid-WAIT:** use `ALU_LAT`=3 and assert `RST` during WAIT →
  - The next cycle is IDLE with `EN` = 0, and no `RSP_VALID` ever appears for the dropped op.
  - With requesters 0 and 3 then both valid, requester 0 is granted first.
- **SUB wrap and OR:** `WIDTH`=8 →
  - SUB with A=2, B=5 gives `RSP_DATA` = 8'hFD.
  - OR with A=8'hF0, B=8'h0F gives 8'hFF.
  - `SEL` = 01 and 11 respectively, during the `EN` cycle only.
